// File: rtl/led_blink_array.sv
// rtl/led_blink_array.sv - array of independently configurable LED blink channels
//
// Each channel runs one of four modes: OFF, ON, BLINK (square wave with a
// programmable half period) or ONESHOT (single high pulse of half+1 cycles,
// then back to OFF with a one-cycle done pulse).
//
// Optional feature macro: LED_BLINK_SYNC_EN
//   defined   -> adds input sync; a high sync phase-aligns every BLINK channel
//   undefined -> no sync port and no alignment logic
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cfg_valid  in   configuration write request
//   cfg_ready  out  high whenever out of reset
//   cfg_ch     in   target channel index (4 bits)
//   cfg_mode   in   0=OFF 1=ON 2=BLINK 3=ONESHOT
//   cfg_half   in   half-period value
//   cfg_err    out  one-cycle pulse after a write to a nonexistent channel
//   light      out  registered LED outputs, bit i = channel i
//   done       out  one-cycle pulse per channel at ONESHOT completion
//   sync       in   (LED_BLINK_SYNC_EN only) phase-align BLINK channels
module led_blink_array #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 16,
    parameter int DEFAULT_HALF = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
`ifdef LED_BLINK_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] light,
    output logic [NUM_CH-1:0] done
);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_ON      = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_ONESHOT = 2'd3;

    // Five bits so that NUM_CH = 16 compares correctly against a 4-bit index.
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    // Per-channel state
    logic [1:0]       mode_q [NUM_CH];
    logic [CNT_W-1:0] half_q [NUM_CH];
    logic [CNT_W-1:0] cnt_q  [NUM_CH];
    logic [NUM_CH-1:0] light_q;
    logic [NUM_CH-1:0] done_q;
    logic              err_q;

    logic [1:0]       mode_d [NUM_CH];
    logic [CNT_W-1:0] half_d [NUM_CH];
    logic [CNT_W-1:0] cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] light_d;
    logic [NUM_CH-1:0] done_d;
    logic              err_d;

    logic sync_hit;

`ifdef LED_BLINK_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Configuration is always accepted while the block is out of reset.
    assign cfg_ready = rst_n;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= MODE_BLINK;
                half_q[i] <= CNT_W'(DEFAULT_HALF);
                cnt_q[i]  <= '0;
            end
            light_q <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mode_q[i] <= mode_d[i];
                half_q[i] <= half_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            light_q <= light_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. Priority per channel: addressed write, then sync
    // alignment (BLINK only), then the mode's own behaviour. A write on the
    // terminal-count cycle therefore suppresses the toggle / done pulse.
    always_comb begin
        err_d   = cfg_valid && ({1'b0, cfg_ch} >= NUM_CH_W);
        light_d = light_q;
        done_d  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mode_d[i] = mode_q[i];
            half_d[i] = half_q[i];
            cnt_d[i]  = cnt_q[i];

            if (cfg_valid && (cfg_ch == 4'(i))) begin
                mode_d[i]  = cfg_mode;
                half_d[i]  = cfg_half;
                cnt_d[i]   = '0;
                light_d[i] = (cfg_mode == MODE_ON) || (cfg_mode == MODE_ONESHOT);
            end else if (sync_hit && (mode_q[i] == MODE_BLINK)) begin
                cnt_d[i]   = '0;
                light_d[i] = 1'b0;
            end else begin
                case (mode_q[i])
                    MODE_OFF: begin
                        cnt_d[i]   = '0;
                        light_d[i] = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d[i]   = '0;
                        light_d[i] = 1'b1;
                    end
                    MODE_BLINK: begin
                        // >= keeps the counter bounded by half even if it
                        // were ever found above it.
                        if (cnt_q[i] >= half_q[i]) begin
                            cnt_d[i]   = '0;
                            light_d[i] = ~light_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        if (cnt_q[i] >= half_q[i]) begin
                            cnt_d[i]   = '0;
                            light_d[i] = 1'b0;
                            mode_d[i]  = MODE_OFF;
                            done_d[i]  = 1'b1;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + 1'b1;
                            light_d[i] = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        light   = light_q;
        done    = done_q;
        cfg_err = err_q;
    end

endmodule

// File: doc/led_blink_array.md
LED_BLINK_ARRAY -- requirements
Module: led_blink_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent LED channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of per-channel half-period counter and cfg_half.
REQ-003 SHALL have parameter DEFAULT_HALF, default 10, meaning half-period loaded into every channel at reset.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  configuration write request.
REQ-007 SHALL have port cfg_ready  output  1  block accepts configuration this cycle.
REQ-008 SHALL have port cfg_ch  input  4  target channel index.
REQ-009 SHALL have port cfg_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=ONESHOT.
REQ-010 SHALL have port cfg_half  input  CNT_W  half-period value for target channel.
REQ-011 SHALL have port cfg_err  output  1  one-cycle pulse, rejected write.
REQ-012 SHALL have port light  output  NUM_CH  registered LED outputs, bit i = channel i.
REQ-013 SHALL have port done  output  NUM_CH  one-cycle pulse per channel at ONESHOT completion.

Function
REQ-014 Each channel SHALL hold mode (2b), half (CNT_W), counter (CNT_W), light bit.
REQ-015 cfg_ready SHALL be 1 whenever rst_n is high; a write is accepted when cfg_valid && cfg_ready.
REQ-016 Accepted write with cfg_ch < NUM_CH SHALL, on that edge, load mode and half, clear counter; light next cycle = 0 for OFF/BLINK, 1 for ON/ONESHOT.
REQ-017 Accepted write with cfg_ch >= NUM_CH SHALL change no state and assert cfg_err for exactly the next cycle.
REQ-018 OFF: light held 0, counter held 0.
REQ-019 ON: light held 1, counter held 0.
REQ-020 BLINK: counter increments each cycle; when counter == half, counter <= 0 and light toggles; light period = 2*(half+1) cycles; half=0 toggles every cycle.
REQ-021 ONESHOT: light 1 while counter counts 0..half; on the cycle counter == half, light <= 0, mode <= OFF, done bit pulses high for the next cycle only.
REQ-022 Counter SHALL never exceed half; no wrap beyond half; arithmetic unsigned, CNT_W bits.
REQ-023 A write to a channel in the same cycle as its terminal count SHALL win: no toggle, no done pulse, new config applied.
REQ-024 Writes SHALL affect only the addressed channel; other channels continue unperturbed.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to light, done, cfg_err.

Reset
REQ-026 rst_n low SHALL asynchronously force: every mode = BLINK, half = DEFAULT_HALF, counter = 0, light = 0, done = 0, cfg_err = 0, cfg_ready = 0.
REQ-027 Reset asserted mid-blink or mid-ONESHOT SHALL abort with no done pulse.
REQ-028 After rst_n deasserts, first counter increment SHALL occur on the first rising clk edge; first toggle DEFAULT_HALF+1 edges later.

Configuration
REQ-029 Macro LED_BLINK_SYNC_EN defined: SHALL add input port sync (1b); when sync=1, every channel in BLINK gets counter <= 0 and light <= 0 on that edge (phase alignment); other modes unaffected; a same-cycle write to a channel overrides sync for that channel.
REQ-030 Macro LED_BLINK_SYNC_EN undefined: port sync SHALL not exist and no phase-alignment logic is built.

Verification
REQ-031 Reset release, no writes, defaults -> every light toggles first at edge 11, then every 11 cycles, all channels in phase.
REQ-032 Write ch1 BLINK half=2, then ch2 ONESHOT half=4 -> ch1 period 6 cycles; ch2 high 5 cycles, done[2] pulses once, ch2 then stays 0; ch0/ch3 unchanged.
REQ-033 Write ch0 ON, then ch0 OFF, then cfg_ch=7 with NUM_CH=4 -> light[0] 1 then 0; cfg_err high exactly one cycle; no channel state changed.
REQ-034 Write ch3 BLINK half=0 coinciding with ch3 terminal count -> no toggle that edge, then toggles every cycle.
REQ-035 rst_n low during ONESHOT half=20 at count 7 -> light 0 immediately, no done pulse, defaults restored.
REQ-036 With LED_BLINK_SYNC_EN: ch0 half=3, ch1 half=5, pulse sync -> both lights 0, counters 0 next cycle; ch0 toggles 4, ch1 6 cycles after sync.
